// File: rtl/ff_bank_multimode.sv
// ff_bank_multimode: WIDTH-bit register bank. Each bit can act as a D, T or
// JK flip-flop, or the whole bank can act as a synchronous up/down counter.
// The bank also supports parallel load, a clock enable and change detection.
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (q <= RST_VAL, chg <= 0)
//   ce   : enable for mode operations (does not gate ld or rst)
//   ld   : parallel load, q <= a
//   mode : 00 D, 01 T, 10 JK, 11 COUNT
//   a    : D data / T mask / J vector / COUNT a[0] = count enable
//   b    : K vector (JK) / COUNT b[0] = direction (0 up, 1 down)
//   q    : registered state
//   qn   : ~q
//   tc   : terminal count (combinational), high the cycle before a wrap
//   chg  : registered, high for the cycle after any q bit changed

// One bit of the bank. The bit holds its own flop and also exports its
// next-state value, so the top level can detect changes.
module ff_bank_lane #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic       ce,
  input  logic [1:0] mode,
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cnt_tgl,  // counter-chain toggle request for this bit
  output logic       q_o,
  output logic       nxt_o
);
  logic q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = a_i;
    end else if (ce) begin
      case (mode)
        2'b00: q_d = a_i;
        2'b01: q_d = q_q ^ a_i;
        2'b10: begin
          case ({a_i, b_i})
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            2'b11:   q_d = ~q_q;
            default: q_d = q_q;
          endcase
        end
        default: q_d = q_q ^ cnt_tgl;
      endcase
    end
  end

  // Reset is checked first, so X on any other input cannot reach q while
  // rst is high.
  always_ff @(posedge clk) begin
    if (rst) q_q <= RST_BIT;
    else     q_q <= q_d;
  end

  assign q_o   = q_q;
  assign nxt_o = q_d;
endmodule

module ff_bank_multimode #(
  parameter int                WIDTH   = 4,
  parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             ld,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic             chg
);
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] cnt_tgl;
  // low_one[i] / low_zero[i]: every bit below i is 1 / 0. Index WIDTH covers
  // the whole bank, which is exactly the terminal-count condition.
  logic [WIDTH:0]   low_one;
  logic [WIDTH:0]   low_zero;
  logic             cnt_en;
  logic             cnt_dn;
  logic             chg_d, chg_q;

  assign cnt_en      = a[0];
  assign cnt_dn      = b[0];
  assign low_one[0]  = 1'b1;
  assign low_zero[0] = 1'b1;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      assign low_one[i+1]  = low_one[i]  &  q[i];
      assign low_zero[i+1] = low_zero[i] & ~q[i];
      // T-flop counter chain: bit i toggles once all lower bits are at the
      // carry (up) or borrow (down) value. Bit 0 sees an empty product.
      assign cnt_tgl[i] = cnt_en & (cnt_dn ? low_zero[i] : low_one[i]);

      ff_bank_lane #(.RST_BIT(RST_VAL[i])) u_lane (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .ce      (ce),
        .mode    (mode),
        .a_i     (a[i]),
        .b_i     (b[i]),
        .cnt_tgl (cnt_tgl[i]),
        .q_o     (q[i]),
        .nxt_o   (nxt[i])
      );
    end
  endgenerate

  assign qn = ~q;

  // High while the next counting edge wraps the bank. Cascaded banks use this
  // signal as their count enable.
  assign tc = (mode == 2'b11) & ce & cnt_en & ~ld & ~rst &
              ((~cnt_dn & low_one[WIDTH]) | (cnt_dn & low_zero[WIDTH]));

  always_comb begin
    chg_d = |(nxt ^ q);
  end

  always_ff @(posedge clk) begin
    if (rst) chg_q <= 1'b0;
    else     chg_q <= chg_d;
  end

  assign chg = chg_q;
endmodule

// File: tb/tb_ff_bank_multimode.sv
module tb_ff_bank_multimode;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=4, reset value 0
  logic       ce4, ld4, tc4, chg4;
  logic [1:0] mode4;
  logic [3:0] a4, b4, q4, qn4;
  // WIDTH=8, reset value A5
  logic       ce8, ld8, tc8, chg8;
  logic [1:0] mode8;
  logic [7:0] a8, b8, q8, qn8;
  // WIDTH=1
  logic       ce1, ld1, tc1, chg1;
  logic [1:0] mode1;
  logic [0:0] a1, b1, q1, qn1;

  int total = 0;
  int bad   = 0;

  ff_bank_multimode #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .ce(ce4), .ld(ld4), .mode(mode4), .a(a4), .b(b4),
    .q(q4), .qn(qn4), .tc(tc4), .chg(chg4));
  ff_bank_multimode #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .ce(ce8), .ld(ld8), .mode(mode8), .a(a8), .b(b8),
    .q(q8), .qn(qn8), .tc(tc8), .chg(chg8));
  ff_bank_multimode #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .ce(ce1), .ld(ld1), .mode(mode1), .a(a1), .b(b1),
    .q(q1), .qn(qn1), .tc(tc1), .chg(chg1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; ld4 = 1'b1; ce4 = 1'b1; a4 = 4'hF; mode4 = 2'b00;
    tick; tick;
    total++; if (q4 !== 4'h0) begin bad++; $display("FAIL rst_q4 got=%h exp=0", q4); end
    total++; if (qn4 !== 4'hF) begin bad++; $display("FAIL rst_qn4 got=%h exp=f", qn4); end
    total++; if (chg4 !== 1'b0) begin bad++; $display("FAIL rst_chg4 got=%b exp=0", chg4); end
    total++; if (q8 !== 8'hA5) begin bad++; $display("FAIL rst_q8 got=%h exp=a5", q8); end
    total++; if (qn8 !== 8'h5A) begin bad++; $display("FAIL rst_qn8 got=%h exp=5a", qn8); end
    total++; if (q1 !== 1'b0) begin bad++; $display("FAIL rst_q1 got=%b exp=0", q1); end
    // unknown inputs under reset must not leak into state
    ld4 = 1'bx; ce4 = 1'bx; a4 = 4'bxxxx; mode4 = 2'bxx; b4 = 4'bxxxx;
    tick;
    total++; if (q4 !== 4'h0) begin bad++; $display("FAIL rst_x_q4 got=%h exp=0", q4); end
    total++; if (chg4 !== 1'b0) begin bad++; $display("FAIL rst_x_chg4 got=%b exp=0", chg4); end
    ld4 = 1'b0; ce4 = 1'b0; a4 = 4'h0; b4 = 4'h0; mode4 = 2'b00;
    rst = 1'b0;
    tick;
    total++; if (q4 !== 4'h0) begin bad++; $display("FAIL hold_q4 got=%h exp=0", q4); end
    total++; if (chg4 !== 1'b0) begin bad++; $display("FAIL hold_chg4 got=%b exp=0", chg4); end
  endtask

  task automatic test_d_mode;
    mode4 = 2'b00; ce4 = 1'b1; a4 = 4'h9;
    tick;
    total++; if (q4 !== 4'h9) begin bad++; $display("FAIL d_q got=%h exp=9", q4); end
    total++; if (chg4 !== 1'b1) begin bad++; $display("FAIL d_chg got=%b exp=1", chg4); end
    ce4 = 1'b0; a4 = 4'h3;
    tick;
    total++; if (q4 !== 4'h9) begin bad++; $display("FAIL d_ce0_q got=%h exp=9", q4); end
    total++; if (chg4 !== 1'b0) begin bad++; $display("FAIL d_ce0_chg got=%b exp=0", chg4); end
    // clear back to 0 for the T sequence
    ld4 = 1'b1; a4 = 4'h0;
    tick;
    ld4 = 1'b0;
  endtask

  task automatic test_t_mode;
    logic [3:0] exp_q [3];
    exp_q[0] = 4'h5; exp_q[1] = 4'h0; exp_q[2] = 4'h5;
    mode4 = 2'b01; ce4 = 1'b1; a4 = 4'b0101;
    for (int k = 0; k < 3; k++) begin
      tick;
      total++; if (q4 !== exp_q[k]) begin bad++; $display("FAIL t_q%0d got=%h exp=%h", k, q4, exp_q[k]); end
      total++; if (chg4 !== 1'b1) begin bad++; $display("FAIL t_chg%0d got=%b exp=1", k, chg4); end
    end
    a4 = 4'h0;
    tick;
    total++; if (q4 !== 4'h5) begin bad++; $display("FAIL t_mask0_q got=%h exp=5", q4); end
    total++; if (chg4 !== 1'b0) begin bad++; $display("FAIL t_mask0_chg got=%b exp=0", chg4); end
    // load of the current value is not a change
    ld4 = 1'b1; a4 = 4'h5;
    tick;
    total++; if (chg4 !== 1'b0) begin bad++; $display("FAIL ld_same_chg got=%b exp=0", chg4); end
    ld4 = 1'b0;
  endtask

  task automatic test_jk_mode;
    ld4 = 1'b1; a4 = 4'b1100;
    tick;
    total++; if (q4 !== 4'b1100) begin bad++; $display("FAIL jk_ld got=%b exp=1100", q4); end
    ld4 = 1'b0; mode4 = 2'b10; ce4 = 1'b1; a4 = 4'b1010; b4 = 4'b0110;
    tick;
    total++; if (q4 !== 4'b1010) begin bad++; $display("FAIL jk_q got=%b exp=1010", q4); end
    total++; if (chg4 !== 1'b1) begin bad++; $display("FAIL jk_chg got=%b exp=1", chg4); end
    total++; if (tc4 !== 1'b0) begin bad++; $display("FAIL jk_tc got=%b exp=0", tc4); end
  endtask

  task automatic test_count_up;
    ld4 = 1'b1; a4 = 4'hD; b4 = 4'h0;
    tick;
    ld4 = 1'b0; mode4 = 2'b11; ce4 = 1'b1; a4 = 4'h1; b4 = 4'h0;
    #1;
    total++; if (tc4 !== 1'b0) begin bad++; $display("FAIL up_tc_d got=%b exp=0", tc4); end
    tick;
    total++; if (q4 !== 4'hE) begin bad++; $display("FAIL up_e got=%h exp=e", q4); end
    tick;
    total++; if (q4 !== 4'hF) begin bad++; $display("FAIL up_f got=%h exp=f", q4); end
    total++; if (tc4 !== 1'b1) begin bad++; $display("FAIL up_tc_f got=%b exp=1", tc4); end
    tick;
    total++; if (q4 !== 4'h0) begin bad++; $display("FAIL up_wrap got=%h exp=0", q4); end
    total++; if (chg4 !== 1'b1) begin bad++; $display("FAIL up_wrap_chg got=%b exp=1", chg4); end
    tick;
    total++; if (q4 !== 4'h1) begin bad++; $display("FAIL up_1 got=%h exp=1", q4); end
    ce4 = 1'b0;
    tick;
    total++; if (q4 !== 4'h1) begin bad++; $display("FAIL up_ce0 got=%h exp=1", q4); end
    total++; if (tc4 !== 1'b0) begin bad++; $display("FAIL up_ce0_tc got=%b exp=0", tc4); end
  endtask

  task automatic test_count_down_prio;
    ce4 = 1'b1; b4 = 4'h1; a4 = 4'h1;
    tick;
    total++; if (q4 !== 4'h0) begin bad++; $display("FAIL dn_0 got=%h exp=0", q4); end
    total++; if (tc4 !== 1'b1) begin bad++; $display("FAIL dn_tc got=%b exp=1", tc4); end
    // load wins over a count that would otherwise wrap; tc masked by ld
    ld4 = 1'b1; a4 = 4'h7;
    #1;
    total++; if (tc4 !== 1'b0) begin bad++; $display("FAIL ld_tc got=%b exp=0", tc4); end
    ld4 = 1'b0; a4 = 4'h1;
    tick;
    total++; if (q4 !== 4'hF) begin bad++; $display("FAIL dn_wrap got=%h exp=f", q4); end
    tick;
    total++; if (q4 !== 4'hE) begin bad++; $display("FAIL dn_e got=%h exp=e", q4); end
    ld4 = 1'b1; a4 = 4'h7;
    tick;
    total++; if (q4 !== 4'h7) begin bad++; $display("FAIL ld_mid got=%h exp=7", q4); end
    rst = 1'b1; ld4 = 1'b1; a4 = 4'h0;
    #1;
    total++; if (tc4 !== 1'b0) begin bad++; $display("FAIL rst_tc got=%b exp=0", tc4); end
    tick;
    total++; if (q4 !== 4'h0) begin bad++; $display("FAIL rst_ld_q got=%h exp=0", q4); end
    total++; if (chg4 !== 1'b0) begin bad++; $display("FAIL rst_ld_chg got=%b exp=0", chg4); end
    rst = 1'b0; ld4 = 1'b0; ce4 = 1'b0;
    // count enable low in COUNT mode holds
    ce4 = 1'b1; a4 = 4'h0; b4 = 4'h0;
    tick;
    total++; if (q4 !== 4'h0) begin bad++; $display("FAIL cnt_en0 got=%h exp=0", q4); end
    ce4 = 1'b0;
  endtask

  task automatic test_width8;
    // reset value was checked earlier; exercise full-width carry chain
    ld8 = 1'b1; a8 = 8'h0F;
    tick;
    ld8 = 1'b0; mode8 = 2'b11; ce8 = 1'b1; a8 = 8'h01; b8 = 8'h00;
    tick;
    total++; if (q8 !== 8'h10) begin bad++; $display("FAIL w8_carry got=%h exp=10", q8); end
    ld8 = 1'b1; a8 = 8'hFF;
    tick;
    ld8 = 1'b0; a8 = 8'h01;
    #1;
    total++; if (tc8 !== 1'b1) begin bad++; $display("FAIL w8_tc got=%b exp=1", tc8); end
    tick;
    total++; if (q8 !== 8'h00) begin bad++; $display("FAIL w8_wrap got=%h exp=00", q8); end
    total++; if (tc8 !== 1'b0) begin bad++; $display("FAIL w8_tc0 got=%b exp=0", tc8); end
    b8 = 8'h01;
    #1;
    total++; if (tc8 !== 1'b1) begin bad++; $display("FAIL w8_dn_tc got=%b exp=1", tc8); end
    tick;
    total++; if (q8 !== 8'hFF) begin bad++; $display("FAIL w8_dn_wrap got=%h exp=ff", q8); end
    tick;
    total++; if (q8 !== 8'hFE) begin bad++; $display("FAIL w8_dn got=%h exp=fe", q8); end
    ce8 = 1'b0;
  endtask

  task automatic test_width1;
    logic exp_q [3];
    exp_q[0] = 1'b1; exp_q[1] = 1'b0; exp_q[2] = 1'b1;
    mode1 = 2'b01; ce1 = 1'b1; a1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      total++; if (q1 !== exp_q[k]) begin bad++; $display("FAIL w1_t%0d got=%b exp=%b", k, q1, exp_q[k]); end
    end
    total++; if (qn1 !== 1'b0) begin bad++; $display("FAIL w1_qn got=%b exp=0", qn1); end
    mode1 = 2'b11; b1 = 1'b0;
    #1;
    total++; if (tc1 !== 1'b1) begin bad++; $display("FAIL w1_tc got=%b exp=1", tc1); end
    tick;
    total++; if (q1 !== 1'b0) begin bad++; $display("FAIL w1_wrap got=%b exp=0", q1); end
    ce1 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ce4 = 1'b0; ld4 = 1'b0; mode4 = 2'b00; a4 = '0; b4 = '0;
    ce8 = 1'b0; ld8 = 1'b0; mode8 = 2'b00; a8 = '0; b8 = '0;
    ce1 = 1'b0; ld1 = 1'b0; mode1 = 2'b00; a1 = '0; b1 = '0;
    test_reset;
    test_d_mode;
    test_t_mode;
    test_jk_mode;
    test_count_up;
    test_count_down_prio;
    test_width8;
    test_width1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ff_bank_multimode.md
Name: ff_bank_multimode

Overview:
- Parametrised successor to the single-bit T flip-flop: a WIDTH-bit register bank.
- The bank can run in D, T, JK or synchronous-counter mode, with parallel load, clock enable and change detection.
- Used as the generic storage/toggle primitive in the sequential-circuit library; drives q and qn like the single-bit flops.

Parameters:
- WIDTH, 4, number of flip-flops in the bank (≥1).
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  clock enable for mode operations; has no effect on ld or rst.
- ld  input  1  parallel load: q <= a.
- mode  input  2  operating mode: 00 D, 01 T, 10 JK, 11 COUNT.
- a  input  WIDTH  operand depends on mode: D data / T toggle mask / J vector / COUNT a[0] = count enable.
- b  input  WIDTH  K vector in JK mode; b[0] = direction in COUNT mode (0 up, 1 down); ignored otherwise.
- q  output  WIDTH  registered state.
- qn  output  WIDTH  always ~q (combinational).
- tc  output  1  terminal count, combinational.
- chg  output  1  registered; 1 for the cycle after any q bit changed.

Behaviour:
- One clock domain. All state updates happen on the rising edge of clk.
- Priority per edge: rst > ld > (ce && mode op) > hold.
- Reset (rst=1 at edge):
  - q <= RST_VAL, chg <= 0.
  - Overrides ld, ce and an in-progress count.
  - Reset mid-count restarts from RST_VAL; no partial state is kept.
- Load (ld=1, rst=0): q <= a, regardless of ce or mode.
- ce=0, ld=0: q holds.
- With ce=1, ld=0:
  - D (00): q <= a.
  - T (01): q <= q ^ a, bitwise; a bit with a[i]=1 toggles.
  - JK (10), per bit (a[i],b[i]):
    - 00 hold, 01 clear, 10 set, 11 toggle.
  - COUNT (11):
    - If a[0]=1: q <= q+1 when b[0]=0, q <= q-1 when b[0]=1, modulo 2^WIDTH.
    - If a[0]=0: q holds.
    - Implemented as a synchronous T-flop chain: bit i toggles when all lower bits are 1 (up) or all 0 (down); bit 0 always toggles when enabled.
- Wrap-around:
  - Up from all-ones gives zero.
  - Down from zero gives all-ones.
  - No saturation.
- tc = (mode==11) & ce & a[0] & ~ld & ((~b[0] & q==all-ones) | (b[0] & q==0)).
  - tc is asserted in the cycle before the wrap edge, allowing cascading of banks.
  - tc is 0 in all other modes and during rst.
- chg:
  - Registered: chg <= (next_q != q) on every edge with rst=0.
  - Goes high for exactly one cycle per changing edge and stays high through consecutive changing edges.
  - An ld of the current value, or a T mask of 0, gives chg=0.
- Mode changes take effect on the same edge; there is no pipelining and no hidden state besides q and chg.
- Latency: one clock from inputs to q and chg. qn and tc are combinational from the current q and inputs.
- X on inputs while rst=1 must not propagate into q.

Test Plan:
- Reset: rst=1 for 2 edges with a=4'hF, ld=1, ce=1 -> q=0000, qn=1111, chg=0; then rst=0, hold -> q stays 0000.
- T mode: mode=01, ce=1, a=4'b0101 for 3 edges from q=0000 -> q=0101, 0000, 0101; chg=1 each cycle. Then a=0 -> q holds, chg drops to 0 the next cycle.
- JK mode: load q=4'b1100, then mode=10, a=4'b1010, b=4'b0110 -> q=4'b1010 (bit3 set, bit2 clear, bit1 toggle 0→1, bit0 hold 0).
- COUNT up with wrap: load 4'hD, mode=11, a[0]=1, b[0]=0 -> q=E, F (tc=1 while q=F), 0, 1. Then ce=0 -> q holds 1, tc=0.
- COUNT down and priority:
  - From q=1, b[0]=1 -> q=0 (tc=1), then F.
  - Assert ld=1 with a=4'h7 mid-count -> q=7 (load wins over count); tc=0 while ld=1.
  - Assert rst with ld=1 -> q=0.
- Parameter sweep: WIDTH=1 and WIDTH=8, RST_VAL=8'hA5.
  - Reset -> q=A5.
  - COUNT up from FF -> q=00, with tc=1 the cycle before.
  - WIDTH=1 T mode with a=1 matches a plain T flip-flop: q alternates 1,0,1.
